// File: rtl/execute_divider.sv
`default_nettype none
// ============================================================================
// Module      : execute_divider
// Description : Multi-cycle restoring radix-2 DIV/DIVU unit for the execute
//               stage. Produces {HI = remainder, LO = quotient} and requests
//               a pipeline stall while a division is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
);

    localparam int unsigned     C_CNT_W = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_STEPS = C_CNT_W'(WIDTH);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_BY_ZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_signed;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_dividend;   // dividend magnitude, quotient shifts in at LSB
    logic [WIDTH-1:0]   r_divisor;    // divisor magnitude
    logic [WIDTH-1:0]   r_rem;        // partial remainder
    logic [C_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_partial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Operand magnitudes, trial subtraction and final sign correction
    always_comb begin
        w_abs_a   = (div_signed && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
        w_abs_b   = (div_signed && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
        w_partial = {r_rem, r_dividend[WIDTH-1]};
        w_diff    = w_partial - {1'b0, r_divisor};
        // Partial remainder is below 2*divisor, so bit WIDTH of the
        // difference is set exactly when the subtraction went negative.
        w_ge      = ~w_diff[WIDTH];
        w_quot    = (r_signed && (r_neg_a ^ r_neg_b)) ? (~r_dividend + 1'b1) : r_dividend;
        w_rem     = (r_signed && r_neg_a) ? (~r_rem + 1'b1) : r_rem;
    end

    assign stall_req = div_start & ~ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FREE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; annul overrides every state
    always_comb begin
        w_next_state = r_state;
        if (annul) begin
            w_next_state = S_FREE;
        end else begin
            case (r_state)
                S_FREE: begin
                    if (div_start) begin
                        w_next_state = (opdata2 == '0) ? S_BY_ZERO : S_ON;
                    end
                end
                S_BY_ZERO: w_next_state = S_END;
                S_ON: begin
                    if (r_cnt == C_STEPS) begin
                        w_next_state = S_END;
                    end
                end
                S_END: begin
                    if (!div_start) begin
                        w_next_state = S_FREE;
                    end
                end
                default: w_next_state = S_FREE;
            endcase
        end
    end

    // Datapath: operand capture, one quotient bit per cycle, result load
    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            ready      <= 1'b0;
            r_signed   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
        end else if (annul) begin
            result <= '0;
            ready  <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    ready  <= 1'b0;
                    result <= '0;
                    if (div_start) begin
                        r_signed   <= div_signed;
                        r_neg_a    <= div_signed & opdata1[WIDTH-1];
                        r_neg_b    <= div_signed & opdata2[WIDTH-1];
                        r_dividend <= w_abs_a;
                        r_divisor  <= w_abs_b;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_BY_ZERO: begin
                    result <= '0;
                end
                S_ON: begin
                    if (r_cnt != C_STEPS) begin
                        r_dividend <= {r_dividend[WIDTH-2:0], w_ge};
                        r_rem      <= w_ge ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
                        r_cnt      <= r_cnt + C_ONE;
                    end else begin
                        result <= {w_rem, w_quot};
                        ready  <= 1'b1;
                    end
                end
                S_END: begin
                    if (div_start) begin
                        ready <= 1'b1;
                    end else begin
                        ready  <= 1'b0;
                        result <= '0;
                    end
                end
                default: begin
                    ready  <= 1'b0;
                    result <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_divider
// Description : Self-checking bench for execute_divider: directed corner
//               cases plus random operands against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_divider;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    int n_checks;
    int n_fail;

    execute_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit integer division, C truncation semantics, x/0 -> 0
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] exp;
        int n;
        exp = model(a, b, s);
        @(negedge clk);
        opdata1 = a; opdata2 = b; div_signed = s; div_start = 1'b1;
        #1 check("stall_first", 64'(stall_req), 64'd1);
        @(posedge clk);                      // acceptance edge
        @(negedge clk);
        opdata1 = $urandom; opdata2 = $urandom; div_signed = 1'($urandom_range(0, 1));
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (ready) break;
            check("stall_busy", 64'(stall_req), 64'd1);
        end
        check("latency", 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
        check("result", result, exp);
        check("stall_at_ready", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        check("hold_ready", 64'(ready), 64'd1);
        check("hold_result", result, exp);
        @(negedge clk);
        div_start = 1'b0;
        @(posedge clk); #1;
        check("drop_ready", 64'(ready), 64'd0);
        check("drop_result", result, 64'd0);
        check("drop_stall", 64'(stall_req), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; div_start = 1'b0; div_signed = 1'b0;
        opdata1 = '0; opdata2 = '0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", 64'(stall_req), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Directed corner cases
        run_div(32'd100, 32'd7, 1'b0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1);
        run_div(32'd5, 32'd0, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0);

        // Annul on the 10th busy cycle
        @(negedge clk);
        opdata1 = 32'd100; opdata2 = 32'd7; div_signed = 1'b0; div_start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1;
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result", result, 64'd0);
        @(negedge clk); annul = 1'b0; div_start = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("annul_no_ready", 64'(ready), 64'd0);
        run_div(32'd9, 32'd3, 1'b0);

        // Reset in the middle of an operation
        @(negedge clk);
        opdata1 = 32'd100; opdata2 = 32'd7; div_signed = 1'b0; div_start = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk); rst = 1'b1; div_start = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_result", result, 64'd0);
        @(negedge clk); rst = 1'b0;
        run_div(32'd9, 32'd3, 1'b0);

        // Random operands, mixing signedness, zero and small divisors
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_divider.md
Name: execute_divider

Overview:
- Multi-cycle 32-bit DIV/DIVU unit in the execute stage. It consumes operands latched by the ID/EX pipeline register and returns a 64-bit {HI, LO} result.
- Raises a stall request toward the pipeline registers while a division is in flight, so ID/EX holds its outputs until the result is ready.
- Performs a restoring radix-2 division, one quotient bit per cycle, on operand magnitudes, then applies MIPS sign rules.

Parameters:
- WIDTH, 32, operand width in bits. Result is 2*WIDTH bits; the step counter is sized to count WIDTH steps.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- div_start  input  1  request a division; held high by execute until ready is seen
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled on acceptance
- opdata1  input  WIDTH  dividend; sampled on acceptance
- opdata2  input  WIDTH  divisor; sampled on acceptance
- annul  input  1  cancel the in-flight op (flush or exception); priority over everything except rst
- result  output  2*WIDTH  {remainder[63:32] = HI, quotient[31:0] = LO}; registered
- ready  output  1  result valid; registered
- stall_req  output  1  combinational: div_start & ~ready

Behaviour:
- Reset (rst=1 at clk edge): state FREE, result = 0, ready = 0, counter = 0, internal dividend/divisor/partial-remainder registers = 0. Reset mid-op aborts the op with no residual effect.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - If div_start & ~annul and opdata2 == 0: go to BY_ZERO.
  - If div_start & ~annul and opdata2 != 0: go to ON.
  - On acceptance, latch div_signed, the operand signs, and the operand magnitudes (|x| when signed and the MSB is 1, else x). Clear the counter and the partial remainder.
  - Otherwise stay in FREE with ready = 0.
- BY_ZERO: next cycle go to END with result = 0 and ready = 1.
- ON:
  - Each cycle: shift {rem, dividend} left by 1 and trial-subtract the divisor magnitude from rem.
  - If the difference is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - Increment the counter. After WIDTH steps (counter reaches WIDTH), go to END.
- Entering END from ON:
  - quotient = negate(q) if signed and the dividend and divisor signs differ, else q.
  - remainder = negate(r) if signed and the dividend is negative, else r.
  - Load result; ready = 1.
- END: hold result and ready = 1 while div_start = 1. When div_start = 0, go to FREE with ready = 0 and result = 0.
- annul = 1 in any state: next state FREE, ready = 0, result = 0. Applies in ON, BY_ZERO, and END, and also blocks acceptance in FREE.
- Latency:
  - Start accepted at edge E0 (FREE to ON).
  - Ready rises after edge E0+WIDTH+1, i.e. 33 edges for WIDTH = 32.
  - Divide-by-zero: ready after E0+2.
- stall_req is 0 whenever div_start = 0. It is 1 from the first start cycle through the last cycle before ready, and falls in the same cycle ready rises.
- Arithmetic is modulo 2^WIDTH. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no trap.
- Operand changes on opdata*/div_signed after acceptance are ignored.

Test Plan:
- DIVU 100 / 7 (start held) -> ready rises 33 edges after acceptance; result = {0x00000002, 0x0000000E}; stall_req is 1 until that cycle, then 0.
- DIV 0xFFFFFFF9 (-7) / 2 -> result = {0xFFFFFFFF, 0xFFFFFFFD} (r = -1, q = -3). DIV 7 / 0xFFFFFFFE -> {0x00000001, 0xFFFFFFFD}.
- DIVU 5 / 0 -> ready after 2 edges; result = 0. Drop div_start -> ready = 0 next cycle, state FREE.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Assert annul on the 10th ON cycle -> ready stays 0, internal state FREE next cycle. Then a new DIVU 9 / 3 -> {0, 3} after the full 33-edge latency.
- Assert rst mid-op (cycle 15), then a new DIVU 9 / 3 -> result and ready are 0 the cycle after reset; the new op completes correctly with {0, 3}.
